// File: rtl/softmax_fp_pkg.sv
// Shared FP32 definitions for the SoftMax datapath blocks.
//   - FP32 field positions and widths (sign 31, exponent 30:23, fraction 22:0)
//   - exponent bias and the all-ones exponent
//   - canonical +0 and +inf encodings
//   - state encoding of the exp-sum accumulator
package softmax_fp_pkg;

   localparam int FP_W     = 32;
   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 24;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;

   localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;
   localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      ST_ACCEPT = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_ADD    = 3'd2,
      ST_NORM   = 3'd3,
      ST_ROUND  = 3'd4,
      ST_OUT    = 3'd5
   } acc_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even stage for positive FP32 mantissas.
// Ports:
//   mant_i   24-bit mantissa including the hidden bit
//   guard_i, round_i, sticky_i   bits below the mantissa lsb
//   exp_i    biased exponent of mant_i
//   mant_o   rounded mantissa (renormalised on carry-out)
//   exp_o    exponent after a possible carry-out increment
//   ovf_o    rounded exponent reached the all-ones exponent
module fp_round_rne
   import softmax_fp_pkg::*;
(
   input  logic [MANT_W-1:0] mant_i,
   input  logic              guard_i,
   input  logic              round_i,
   input  logic              sticky_i,
   input  logic [EXP_W-1:0]  exp_i,
   output logic [MANT_W-1:0] mant_o,
   output logic [EXP_W-1:0]  exp_o,
   output logic              ovf_o
);

   logic              round_up;
   logic [MANT_W:0]   mant_inc;
   logic [EXP_W:0]    exp_inc;

   always_comb begin
      round_up = guard_i & (round_i | sticky_i | mant_i[0]);
      mant_inc = {1'b0, mant_i} + {{MANT_W{1'b0}}, round_up};
      // 0xFFFFFF + 1 carries out: the result is exactly 2^24, so shifting
      // right by one loses nothing.
      if (mant_inc[MANT_W]) begin
         mant_o  = mant_inc[MANT_W:1];
         exp_inc = {1'b0, exp_i} + 9'd1;
      end else begin
         mant_o  = mant_inc[MANT_W-1:0];
         exp_inc = {1'b0, exp_i};
      end
      exp_o = exp_inc[EXP_W-1:0];
      ovf_o = (exp_inc >= 9'(EXP_MAX));
   end

endmodule

// File: rtl/fp_exp_sum_accum_32bit.sv
// Sequential FP32 accumulator producing the SoftMax denominator.
// One element is added every 5 cycles (ACCEPT, ALIGN, ADD, NORM, ROUND);
// after N_ELEMS elements the sum is held in OUT until out_ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     element handshake; transfer when both are high
//                         on a rising edge (in_ready only high in ACCEPT)
//   in_data               FP32 element, sign ignored, denormals read as 0
//   out_valid/out_ready   result handshake; out_sum/overflow held while
//                         out_valid is high and out_ready is low
//   out_sum               FP32 sum, sign always 0
//   overflow              sum saturated to +inf for this vector
module fp_exp_sum_accum_32bit
   import softmax_fp_pkg::*;
#(
   parameter int N_ELEMS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic        overflow
);

   localparam int CW = $clog2(N_ELEMS) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N_ELEMS - 1);

   acc_state_e        state_q;
   logic              in_ready_q, out_valid_q, ovf_q;
   logic [31:0]       out_sum_q;
   logic [30:0]       acc_q;       // sign is always 0, so it is not stored
   logic [30:0]       op_q;
   logic [CW-1:0]     cnt_q;
   logic [26:0]       fa_q, fb_q;  // {mantissa[23:0], G, R, S}
   logic [EXP_W-1:0]  exp_q, nexp_q;
   logic              inf_q;
   logic [27:0]       sum_q;
   logic [MANT_W-1:0] nm_q;
   logic              ng_q, nr_q, ns_q;

   // ALIGN stage
   logic [EXP_W-1:0]  exp_a, exp_b, exp_big_d, diff;
   logic [MANT_W-1:0] mant_a, mant_b, mant_big, mant_small;
   logic [53:0]       wide;
   logic [26:0]       fa_d, fb_d;
   logic              inf_d;

   always_comb begin
      exp_a  = acc_q[EXP_MSB:EXP_LSB];
      exp_b  = op_q[EXP_MSB:EXP_LSB];
      mant_a = (exp_a == '0) ? '0 : {1'b1, acc_q[FRAC_W-1:0]};
      mant_b = (exp_b == '0) ? '0 : {1'b1, op_q[FRAC_W-1:0]};
      if (exp_a >= exp_b) begin
         exp_big_d  = exp_a;
         diff       = exp_a - exp_b;
         mant_big   = mant_a;
         mant_small = mant_b;
      end else begin
         exp_big_d  = exp_b;
         diff       = exp_b - exp_a;
         mant_big   = mant_b;
         mant_small = mant_a;
      end
      // Upper 27 bits are the aligned field; everything below folds into sticky.
      wide = {mant_small, 3'b000, 27'd0} >> diff;
      fa_d = {mant_big, 3'b000};
      if (diff >= 8'd27)
         fb_d = {26'd0, |mant_small};
      else
         fb_d = {wide[53:28], wide[27] | (|wide[26:0])};
      inf_d = (exp_a == 8'(EXP_MAX)) || (exp_b == 8'(EXP_MAX));
   end

   // NORM stage
   logic [MANT_W-1:0] nm_d;
   logic              ng_d, nr_d, ns_d;
   logic [EXP_W-1:0]  nexp_d;

   always_comb begin
      if (sum_q[27]) begin
         nm_d   = sum_q[27:4];
         ng_d   = sum_q[3];
         nr_d   = sum_q[2];
         ns_d   = sum_q[1] | sum_q[0];
         nexp_d = exp_q + 8'd1;
      end else begin
         nm_d   = sum_q[26:3];
         ng_d   = sum_q[2];
         nr_d   = sum_q[1];
         ns_d   = sum_q[0];
         nexp_d = exp_q;
      end
   end

   // ROUND stage
   logic [MANT_W-1:0] rmant;
   logic [EXP_W-1:0]  rexp;
   logic              rovf, acc_inf_d;
   logic [30:0]       acc_d;
   logic              unused_bits;

   fp_round_rne u_round (
      .mant_i   (nm_q),
      .guard_i  (ng_q),
      .round_i  (nr_q),
      .sticky_i (ns_q),
      .exp_i    (nexp_q),
      .mant_o   (rmant),
      .exp_o    (rexp),
      .ovf_o    (rovf)
   );

   always_comb begin
      acc_inf_d = inf_q | rovf;
      acc_d     = acc_inf_d ? FP_POS_INF[30:0] : {rexp, rmant[FRAC_W-1:0]};
   end

   // Hidden bit of the rounded mantissa and the input sign are not needed.
   assign unused_bits = rmant[MANT_W-1] ^ in_data[SIGN_BIT];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCEPT;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= FP_ZERO;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         fa_q        <= '0;
         fb_q        <= '0;
         exp_q       <= '0;
         inf_q       <= 1'b0;
         sum_q       <= '0;
         nm_q        <= '0;
         ng_q        <= 1'b0;
         nr_q        <= 1'b0;
         ns_q        <= 1'b0;
         nexp_q      <= '0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (in_valid && in_ready_q) begin
                  op_q       <= in_data[30:0];
                  in_ready_q <= 1'b0;
                  state_q    <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               fa_q    <= fa_d;
               fb_q    <= fb_d;
               exp_q   <= exp_big_d;
               inf_q   <= inf_d;
               state_q <= ST_ADD;
            end
            ST_ADD: begin
               sum_q   <= {1'b0, fa_q} + {1'b0, fb_q};
               state_q <= ST_NORM;
            end
            ST_NORM: begin
               nm_q    <= nm_d;
               ng_q    <= ng_d;
               nr_q    <= nr_d;
               ns_q    <= ns_d;
               nexp_q  <= nexp_d;
               state_q <= ST_ROUND;
            end
            ST_ROUND: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (acc_inf_d) ovf_q <= 1'b1;
               if (cnt_q == CNT_LAST) begin
                  out_sum_q   <= {1'b0, acc_d};
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= ST_ACCEPT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  ovf_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_ACCEPT;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= ST_ACCEPT;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fp_exp_sum_accum_32bit.sv
// Directed bench for fp_exp_sum_accum_32bit with hand-computed sums.
module tb_fp_exp_sum_accum_32bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        overflow;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int last_acc = 0;

   logic [31:0] vec[8];

   fp_exp_sum_accum_32bit #(.N_ELEMS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .overflow  (overflow)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one element and hold it until accepted (bounded wait).
   task automatic send(input logic [31:0] d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept_timeout", {31'd0, n < 50}, 32'd1);
      @(posedge clk); #1;
      last_acc = cyc;
      in_valid = 1'b0;
      in_data  = 32'h0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("out_timeout", {31'd0, n < 50}, 32'd1);
   endtask

   // Full vector with out_ready already high.
   task automatic run_vec(input string tag, input logic [31:0] exp_sum,
                          input logic exp_ovf, input logic chk_rate);
      int prev;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         send(vec[i]);
         if (chk_rate && i > 0) check({tag, "_spacing"}, 32'(last_acc - prev), 32'd5);
         prev = last_acc;
      end
      wait_out();
      check({tag, "_sum"}, out_sum, exp_sum);
      check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_sum", out_sum, 32'h0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);

      // eight 1.0 -> 8.0, with accept spacing
      for (int i = 0; i < 8; i++) vec[i] = 32'h3F80_0000;
      run_vec("ones", 32'h4100_0000, 1'b0, 1'b1);

      // 1.0 .. 8.0 -> 36.0
      vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
      run_vec("ramp", 32'h4210_0000, 1'b0, 1'b0);

      // exact tie, even lsb stays
      vec = '{32'h3F80_0000, 32'h3380_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      run_vec("tie_even", 32'h3F80_0000, 1'b0, 1'b0);

      // exact tie, odd lsb rounds up
      vec = '{32'h3F80_0001, 32'h3380_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      run_vec("tie_odd", 32'h3F80_0002, 1'b0, 1'b0);

      // overflow saturates and sticks
      vec = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h3F80_0000,
              32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      run_vec("ovf", 32'h7F80_0000, 1'b1, 1'b0);

      // back-pressure: eight 0.5 -> 4.0 held for 10 cycles
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(32'h3F00_0000);
      wait_out();
      in_valid = 1'b1;
      in_data  = 32'h3F80_0000;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_sum", out_sum, 32'h4080_0000);
         check("bp_ovf", {31'd0, overflow}, 32'd0);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) vec[i] = 32'h4000_0000;
      run_vec("after_bp", 32'h4180_0000, 1'b0, 1'b0);

      // reset while the 3rd element is in ADD
      send(32'h3F80_0000);
      send(32'h3F80_0000);
      send(32'h3F80_0000);
      @(posedge clk); #1;   // now in ADD
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_sum", out_sum, 32'h0);
      check("midrst_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 8; i++) vec[i] = 32'h3F80_0000;
      run_vec("post_rst", 32'h4100_0000, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
